uart_io_ctrl: RTL and testbench
===============================

# uart_io_ctrl

Memory-mapped responder that sits between the CPU memory stage and the UART byte interface. It decodes memory-stage loads and stores to the UART address window and buffers bytes in both directions through small FIFOs. It also drives the UART handshake signals and returns status or received data to the write-back mux.

## Interface

Parameters:
- `TX_DEPTH`, default 4: TX FIFO entries. Must be a power of 2 and at least 2.
- `RX_DEPTH`, default 4: RX FIFO entries. Must be a power of 2 and at least 2.

Ports:
- `clk` in 1: the single clock. All state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `stall` in 1: pipeline stall. While high, no access takes effect.
- `addrM` in 32: memory-stage effective address (ALU result).
- `opcodeM` in 6: memory-stage opcode.
- `wdataM` in 8: store data, bits [7:0] of rt.
- `uartSel` out 1: high when `addrM` hits the UART window and `opcodeM` is a load. Selects `rdataM` in the write-back mux.
- `rdataM` out 32: load result.
- `txData` out 8: byte to the UART transmitter.
- `txValid` out 1: `txData` is valid.
- `txReady` in 1: the UART accepts the byte.
- `rxData` in 8: byte from the UART receiver.
- `rxValid` in 1: `rxData` is valid.
- `rxReady` out 1: this block can accept `rxData`.

## Operation

Address map. Word-aligned; `addrM[1:0]` is ignored.
- 0x80000000, TX control (read): bit0 = TX FIFO not full; bit1 = sticky TX-drop flag.
- 0x80000004, RX control (read): bit0 = RX FIFO not empty.
- 0x80000008, TX data (store): pushes `wdataM`.
- 0x8000000C, RX data (load): returns the RX FIFO head and pops it.
- Any other 0x8xxxxxxx address: loads return 0, stores are ignored.

Recognised opcodes:
- Loads: lw 0x23, lb 0x20, lbu 0x24.
- Stores: sw 0x2B, sb 0x28.
- Other opcodes are no access.

Load results:
- Status reads, lw and lbu on RX data: zero-extended.
- lb on RX data: sign-extended from bit 7.
- Status bits [31:2] read as 0.

An access is qualified only when `stall`=0. The side effect (push, pop, flag clear) occurs at the next rising edge.

TX path:
- A qualified store to 0x80000008 pushes if the FIFO is not full.
- If the FIFO is full, the byte is discarded and the TX-drop flag is set.
- A qualified load of TX control returns the pre-edge flag value and clears the flag.
- `txValid` = TX not empty; `txData` = TX head.
- Pop when `txValid` && `txReady`.

RX path:
- `rxReady` = RX not full.
- Push `rxData` when `rxValid` && `rxReady`.
- A qualified load of 0x8000000C when the FIFO is empty returns 0x00000000, with no pointer change.

FIFOs:
- Read pointer, write pointer and count are each log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
- Full means count == DEPTH; empty means count == 0.

## Timing

- `rdataM` and `uartSel` are combinational from `addrM`, `opcodeM` and FIFO state, and are valid in the same cycle as the access. The pop or flag clear follows at the edge.
- Push-to-visible latency is one cycle:
  - A byte pushed at edge N appears on `txData`/`txValid` after edge N.
  - An RX byte pushed at edge N is readable after edge N, with RX control bit0 = 1.
- Simultaneous events:
  - TX full, CPU store and UART pop in the same cycle: fullness is evaluated pre-edge, so the store is dropped and the flag is set.
  - TX, one side pushes and the other pops in the same cycle with the FIFO neither full nor empty: both take effect; count is unchanged.
  - RX empty, CPU load and UART push in the same cycle: the load returns 0 with no pop; the push lands.
  - RX, push and pop in the same non-empty, non-full cycle: both take effect; count is unchanged.
- Stall: a held access has no side effect while `stall`=1 and takes effect once, on the first edge with `stall`=0.
- Reset, asynchronous on `reset`=0, including mid-operation:
  - Pointers and counts go to 0 and the TX-drop flag is cleared; FIFO contents are discarded.
  - Outputs during and after reset: `txValid`=0, `txData`=0x00, `rxReady`=1, `uartSel`=0 unless the address decodes, `rdataM`=0.
  - Release is clean: the first edge after release may accept a push.

## Structure

- Package `uart_io_pkg` holds:
  - the four address constants and the window base 0x8;
  - the opcode constants (lw, lb, lbu, sw, sb);
  - the status bit indices.
- Sub-module `sync_fifo` (parameters `WIDTH`, `DEPTH`), instantiated twice with width 8.
  - Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`.
  - Pushes when full and pops when empty are ignored internally.
- Top level holds the address/opcode decode, the TX-drop flag, the load-data extension and the handshake glue.

## Test plan

- Reset, then read TX control and RX control -> 0x00000001 and 0x00000000; `txValid`=0, `rxReady`=1.
- sw 0x41, 0x42 to 0x80000008 with `txReady`=0 -> `txValid`=1, `txData`=0x41; raise `txReady` for 1 cycle -> `txData`=0x42; second pop -> `txValid`=0.
- Five TX stores with `txReady`=0, depth 4 -> the fifth is dropped; TX control reads 0x00000002 (not-full 0, drop 1); a second read -> 0x00000000.
- UART pushes 0xF0 -> lb 0x8000000C returns 0xFFFFFFF0; lbu on a second byte 0xF0 returns 0x000000F0; RX control then reads 0.
- RX full, depth 4 -> `rxReady`=0; one CPU pop -> `rxReady`=1 next cycle; load with `stall`=1 held for 3 cycles -> exactly one pop.
- `reset` asserted with both FIFOs half full -> empty immediately; `txValid`=0; the first load after release returns 0x00000000.

Source files
------------

// File: rtl/uart_io_ctrl_pkg.sv
// Shared constants and decode helpers for the memory-mapped UART responder.
// Address map, opcode encodings and status bit positions live here.
package uart_io_pkg;

    localparam logic [3:0]  WINDOW_BASE  = 4'h8;

    localparam logic [31:0] ADDR_TX_CTRL = 32'h8000_0000;
    localparam logic [31:0] ADDR_RX_CTRL = 32'h8000_0004;
    localparam logic [31:0] ADDR_TX_DATA = 32'h8000_0008;
    localparam logic [31:0] ADDR_RX_DATA = 32'h8000_000C;

    localparam logic [5:0]  OP_LW  = 6'h23;
    localparam logic [5:0]  OP_LB  = 6'h20;
    localparam logic [5:0]  OP_LBU = 6'h24;
    localparam logic [5:0]  OP_SW  = 6'h2B;
    localparam logic [5:0]  OP_SB  = 6'h28;

    localparam int unsigned TX_NOT_FULL_BIT  = 0;
    localparam int unsigned TX_DROP_BIT      = 1;
    localparam int unsigned RX_NOT_EMPTY_BIT = 0;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_LOAD,
        ACC_STORE
    } acc_kind_e;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_TX_CTRL,
        REG_RX_CTRL,
        REG_TX_DATA,
        REG_RX_DATA,
        REG_OTHER
    } reg_sel_e;

    function automatic acc_kind_e decode_op(input logic [5:0] op);
        case (op)
            OP_LW, OP_LB, OP_LBU: return ACC_LOAD;
            OP_SW, OP_SB:         return ACC_STORE;
            default:              return ACC_NONE;
        endcase
    endfunction

    // Low two address bits are masked so byte offsets alias onto the word register.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr);
        logic [31:0] word;
        word = addr & 32'hFFFF_FFFC;
        if (word[31:28] != WINDOW_BASE) return REG_NONE;
        case (word)
            ADDR_TX_CTRL: return REG_TX_CTRL;
            ADDR_RX_CTRL: return REG_RX_CTRL;
            ADDR_TX_DATA: return REG_TX_DATA;
            ADDR_RX_DATA: return REG_RX_DATA;
            default:      return REG_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/uart_io_ctrl_if.sv
// Memory-stage bus plus UART byte handshakes grouped for the UART responder.
interface uart_io_ctrl_if;

    logic        stall;
    logic [31:0] addrM;
    logic [5:0]  opcodeM;
    logic [7:0]  wdataM;
    logic        uartSel;
    logic [31:0] rdataM;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;

    modport master (
        output stall, addrM, opcodeM, wdataM, txReady, rxData, rxValid,
        input  uartSel, rdataM, txData, txValid, rxReady
    );

    modport slave (
        input  stall, addrM, opcodeM, wdataM, txReady, rxData, rxValid,
        output uartSel, rdataM, txData, txValid, rxReady
    );

endinterface

// File: rtl/uart_io_ctrl_sync_fifo.sv
// Single-clock FIFO; pushes when full and pops when empty are ignored.
// dout reads zero while empty so stale storage never leaks to consumers.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_IDX  = (AW+1)'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW:0] bump(input logic [AW:0] p);
        return (p == LAST_IDX) ? '0 : p + (AW+1)'(1);
    endfunction

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_io_ctrl.sv
// UART responder: decodes memory-stage accesses to the UART window, buffers
// bytes through TX/RX FIFOs and returns status or RX data to write-back.
module uart_io_ctrl
    import uart_io_pkg::*;
#(
    parameter int unsigned TX_DEPTH = 4,
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    uart_io_ctrl_if.slave bus
);

    acc_kind_e   acc;
    reg_sel_e    sel;
    logic        is_load;
    logic        tx_store;
    logic        rx_load;
    logic        tx_ctrl_load;

    logic        tx_full;
    logic        tx_empty;
    logic [7:0]  tx_dout;
    logic        tx_pop;
    logic        tx_drop;

    logic        rx_full;
    logic        rx_empty;
    logic [7:0]  rx_dout;
    logic        rx_push;

    logic [31:0] load_data;

    assign acc          = decode_op(bus.opcodeM);
    assign sel          = decode_addr(bus.addrM);
    assign is_load      = (acc == ACC_LOAD) && (sel != REG_NONE);
    assign tx_store     = !bus.stall && (acc == ACC_STORE) && (sel == REG_TX_DATA);
    assign rx_load      = !bus.stall && is_load && (sel == REG_RX_DATA);
    assign tx_ctrl_load = !bus.stall && is_load && (sel == REG_TX_CTRL);

    assign tx_pop      = !tx_empty && bus.txReady;
    assign rx_push     = bus.rxValid && !rx_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_store),
        .pop   (tx_pop),
        .din   (bus.wdataM),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_load),
        .din   (bus.rxData),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Fullness is sampled pre-edge, so a store racing a UART pop on a full FIFO still drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_drop <= 1'b0;
        end else if (tx_store && tx_full) begin
            tx_drop <= 1'b1;
        end else if (tx_ctrl_load) begin
            tx_drop <= 1'b0;
        end
    end

    always_comb begin
        load_data = '0;
        if (reset && is_load) begin
            case (sel)
                REG_TX_CTRL: begin
                    load_data[TX_NOT_FULL_BIT] = !tx_full;
                    load_data[TX_DROP_BIT]     = tx_drop;
                end
                REG_RX_CTRL: load_data[RX_NOT_EMPTY_BIT] = !rx_empty;
                REG_RX_DATA: begin
                    if (bus.opcodeM == OP_LB) load_data = {{24{rx_dout[7]}}, rx_dout};
                    else                      load_data = {24'h0, rx_dout};
                end
                default: load_data = '0;
            endcase
        end
    end

    assign bus.uartSel = is_load;
    assign bus.rdataM  = load_data;
    assign bus.txValid = !tx_empty;
    assign bus.txData  = tx_dout;
    assign bus.rxReady = !rx_full;

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Bench for uart_io_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_io_ctrl;

    localparam int TXD = 4;
    localparam int RXD = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_io_ctrl_if bus ();

    uart_io_ctrl #(
        .TX_DEPTH (TXD),
        .RX_DEPTH (RXD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         drop_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit op_is_load(input logic [5:0] op);
        return op == 6'h23 || op == 6'h20 || op == 6'h24;
    endfunction

    function automatic bit op_is_store(input logic [5:0] op);
        return op == 6'h2B || op == 6'h28;
    endfunction

    function automatic logic [31:0] model_rdata();
        logic [29:0] w;
        logic [31:0] v;
        w = bus.addrM[31:2];
        if (!reset || bus.addrM[31:28] != 4'h8 || !op_is_load(bus.opcodeM)) return 32'h0;
        if (w == 30'h2000_0000)
            return (drop_m ? 32'd2 : 32'd0) + ((tx_q.size() < TXD) ? 32'd1 : 32'd0);
        if (w == 30'h2000_0001) return (rx_q.size() > 0) ? 32'd1 : 32'd0;
        if (w == 30'h2000_0003) begin
            if (rx_q.size() == 0) return 32'h0;
            v = 32'(rx_q[0]);
            if (bus.opcodeM == 6'h20 && v >= 32'd128) v = v | 32'hFFFF_FF00;
            return v;
        end
        return 32'h0;
    endfunction

    task automatic check_outputs();
        logic [31:0] exp_sel;
        logic [31:0] exp_txd;
        exp_sel = (bus.addrM[31:28] == 4'h8 && op_is_load(bus.opcodeM)) ? 32'd1 : 32'd0;
        exp_txd = (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'h0;
        chk("uartSel", 32'(bus.uartSel), exp_sel);
        chk("rdataM",  bus.rdataM, model_rdata());
        chk("txValid", 32'(bus.txValid), (tx_q.size() > 0) ? 32'd1 : 32'd0);
        chk("txData",  32'(bus.txData), exp_txd);
        chk("rxReady", 32'(bus.rxReady), (rx_q.size() < RXD) ? 32'd1 : 32'd0);
    endtask

    task automatic model_clear();
        tx_q.delete();
        rx_q.delete();
        drop_m = 1'b0;
    endtask

    task automatic model_step();
        int  tx_n, rx_n;
        bit  q, cpu_push, cpu_pop, clr, tx_pop, rx_push;
        logic [29:0] w;
        if (!reset) begin
            model_clear();
            return;
        end
        tx_n     = tx_q.size();
        rx_n     = rx_q.size();
        w        = bus.addrM[31:2];
        q        = !bus.stall && bus.addrM[31:28] == 4'h8;
        cpu_push = q && op_is_store(bus.opcodeM) && w == 30'h2000_0002;
        cpu_pop  = q && op_is_load(bus.opcodeM) && w == 30'h2000_0003 && rx_n > 0;
        clr      = q && op_is_load(bus.opcodeM) && w == 30'h2000_0000;
        tx_pop   = tx_n > 0 && bus.txReady;
        rx_push  = bus.rxValid && rx_n < RXD;
        if (cpu_push && tx_n == TXD) drop_m = 1'b1;
        else if (clr)                drop_m = 1'b0;
        if (tx_pop) tx_q.delete(0);
        if (cpu_push && tx_n < TXD) tx_q.push_back(bus.wdataM);
        if (cpu_pop) rx_q.delete(0);
        if (rx_push) rx_q.push_back(bus.rxData);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [31:0] addr, input logic [5:0] op,
                         input logic [7:0] wd, input logic txr, input logic rxv,
                         input logic [7:0] rxd);
        bus.stall   = st;
        bus.addrM   = addr;
        bus.opcodeM = op;
        bus.wdataM  = wd;
        bus.txReady = txr;
        bus.rxValid = rxv;
        bus.rxData  = rxd;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 6'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [31:0] addr;
        logic [5:0]  op;
        logic [3:0]  top;
        idle();
        model_clear();
        cycle();
        cycle();
        #1;
        chk("rst_txValid", 32'(bus.txValid), 32'd0);
        chk("rst_txData",  32'(bus.txData), 32'h0);
        chk("rst_rxReady", 32'(bus.rxReady), 32'd1);
        reset = 1'b1;

        drive(1'b0, 32'h8000_0000, 6'h23, 8'h00, 1'b0, 1'b0, 8'h00);
        #1 chk("tx_ctrl_after_reset", bus.rdataM, 32'h0000_0001);
        chk("rxReady_after_reset", 32'(bus.rxReady), 32'd1);
        cycle();
        drive(1'b0, 32'h8000_0004, 6'h23, 8'h00, 1'b0, 1'b0, 8'h00);
        #1 chk("rx_ctrl_after_reset", bus.rdataM, 32'h0);
        cycle();

        drive(1'b0, 32'h8000_0008, 6'h2B, 8'h41, 1'b0, 1'b0, 8'h00);
        cycle();
        drive(1'b0, 32'h8000_0008, 6'h2B, 8'h42, 1'b0, 1'b0, 8'h00);
        cycle();
        idle();
        #1 chk("tx_head_41", 32'(bus.txData), 32'h41);
        chk("tx_valid_2", 32'(bus.txValid), 32'd1);
        bus.txReady = 1'b1;
        cycle();
        bus.txReady = 1'b0;
        #1 chk("tx_head_42", 32'(bus.txData), 32'h42);
        bus.txReady = 1'b1;
        cycle();
        bus.txReady = 1'b0;
        #1 chk("tx_drained", 32'(bus.txValid), 32'd0);

        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'h8000_0008, 6'h28, 8'(8'h10 + i), 1'b0, 1'b0, 8'h00);
            cycle();
        end
        drive(1'b0, 32'h8000_0000, 6'h23, 8'h00, 1'b0, 1'b0, 8'h00);
        #1 chk("tx_ctrl_full_drop", bus.rdataM, 32'h0000_0002);
        cycle();
        #1 chk("tx_ctrl_drop_cleared", bus.rdataM, 32'h0000_0000);
        cycle();
        idle();
        bus.txReady = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        bus.txReady = 1'b0;

        drive(1'b0, 32'h0, 6'h00, 8'h00, 1'b0, 1'b1, 8'hF0);
        cycle();
        drive(1'b0, 32'h8000_000C, 6'h20, 8'h00, 1'b0, 1'b0, 8'h00);
        #1 chk("lb_sign_ext", bus.rdataM, 32'hFFFF_FFF0);
        cycle();
        drive(1'b0, 32'h0, 6'h00, 8'h00, 1'b0, 1'b1, 8'hF0);
        cycle();
        drive(1'b0, 32'h8000_000E, 6'h24, 8'h00, 1'b0, 1'b0, 8'h00);
        #1 chk("lbu_zero_ext", bus.rdataM, 32'h0000_00F0);
        cycle();
        drive(1'b0, 32'h8000_0004, 6'h23, 8'h00, 1'b0, 1'b0, 8'h00);
        #1 chk("rx_ctrl_empty", bus.rdataM, 32'h0);
        cycle();

        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 32'h0, 6'h00, 8'h00, 1'b0, 1'b1, 8'(i));
            cycle();
        end
        idle();
        #1 chk("rx_full_ready", 32'(bus.rxReady), 32'd0);
        drive(1'b0, 32'h8000_000C, 6'h24, 8'h00, 1'b0, 1'b0, 8'h00);
        #1 chk("rx_pop_1", bus.rdataM, 32'h1);
        cycle();
        idle();
        #1 chk("rx_ready_after_pop", 32'(bus.rxReady), 32'd1);
        drive(1'b1, 32'h8000_000C, 6'h24, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cycle();
            #1 chk("stalled_head", bus.rdataM, 32'h2);
        end
        bus.stall = 1'b0;
        cycle();
        #1 chk("single_pop_after_stall", bus.rdataM, 32'h3);
        idle();

        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h8000_0008, 6'h2B, 8'(8'hA0 + i), 1'b0, 1'b0, 8'h00);
            cycle();
        end
        idle();
        #2 reset = 1'b0;
        #1 model_clear();
        chk("async_rst_txValid", 32'(bus.txValid), 32'd0);
        chk("async_rst_rxReady", 32'(bus.rxReady), 32'd1);
        check_outputs();
        cycle();
        cycle();
        reset = 1'b1;
        drive(1'b0, 32'h8000_000C, 6'h23, 8'h00, 1'b0, 1'b0, 8'h00);
        #1 chk("first_load_after_reset", bus.rdataM, 32'h0);
        cycle();

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 7))
                0: addr = 32'h8000_0000;
                1: addr = 32'h8000_0004;
                2, 3: addr = 32'h8000_0008;
                4: addr = 32'h8000_000C;
                5: addr = 32'h8000_0010 + ($urandom_range(0, 255) << 2);
                6: addr = {4'h8, 28'($urandom)};
                default: begin
                    top = 4'($urandom_range(0, 15));
                    if (top == 4'h8) top = 4'h9;
                    addr = {top, 28'($urandom)};
                end
            endcase
            addr = addr | 32'($urandom_range(0, 3));
            case ($urandom_range(0, 6))
                0: op = 6'h23;
                1: op = 6'h20;
                2: op = 6'h24;
                3: op = 6'h2B;
                4: op = 6'h28;
                default: op = 6'($urandom);
            endcase
            drive(1'($urandom_range(0, 3) == 0), addr, op, 8'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 8'($urandom));
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b0;
                #1 model_clear();
                check_outputs();
                cycle();
                reset = 1'b1;
            end else begin
                cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
